nn_layer_sequencer: RTL and testbench

// - Frame-level controller for the hidden/output neuron datapath. Runs one shared neuron

---
 rtl/nn_layer_sequencer_if.sv | 42 ++++
 rtl/nn_layer_sequencer.sv | 158 +++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Frame-source / datapath handshake bundle for nn_layer_sequencer.
// FrameCnt exists only when NN_SEQ_FRAME_CNT_EN is defined.
interface nn_layer_sequencer_if #(
  parameter int ADDR_W = 7
);
  logic              Start;
  logic              WE;
  logic [ADDR_W-1:0] Address;
  logic              Phase;
  logic [2:0]        NeuronIdx;
  logic              CaptureHid;
  logic              CaptureOut;
  logic              Busy;
  logic              Done;
  logic              Abort;
  logic [2:0]        State;
`ifdef NN_SEQ_FRAME_CNT_EN
  logic [7:0]        FrameCnt;

  modport master (
    input  Start, WE,
    output Address, Phase, NeuronIdx, CaptureHid, CaptureOut,
           Busy, Done, Abort, State, FrameCnt
  );
  modport slave (
    output Start, WE,
    input  Address, Phase, NeuronIdx, CaptureHid, CaptureOut,
           Busy, Done, Abort, State, FrameCnt
  );
`else
  modport master (
    input  Start, WE,
    output Address, Phase, NeuronIdx, CaptureHid, CaptureOut,
           Busy, Done, Abort, State
  );
  modport slave (
    output Start, WE,
    input  Address, Phase, NeuronIdx, CaptureHid, CaptureOut,
           Busy, Done, Abort, State
  );
`endif
endinterface

// File: rtl/nn_layer_sequencer.sv
// Frame controller: issues 5 hidden then 3 output neuron evaluations on a shared datapath.
// Optional frame counter output enabled by defining NN_SEQ_FRAME_CNT_EN.
module nn_layer_sequencer #(
  parameter int N_IN     = 10,
  parameter int N_HID    = 5,
  parameter int N_OUT    = 3,
  parameter int ADDR_W   = 7,
  parameter int HID_BASE = 0,
  parameter int OUT_BASE = 50,
  parameter int RD_LAT   = 1
) (
  input logic                  Clock,
  input logic                  Rst,
  nn_layer_sequencer_if.master seq_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_HID = 3'(N_HID - 1);
  localparam logic [2:0] LAST_OUT = 3'(N_OUT - 1);
  localparam logic [2:0] LAT_LOAD = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

  if ((OUT_BASE + N_OUT * N_HID) > (2 ** ADDR_W)) begin : g_bad_out_range
    $error("nn_layer_sequencer: output weights exceed the address space");
  end
  if ((HID_BASE + N_HID * N_IN) > OUT_BASE) begin : g_bad_hid_range
    $error("nn_layer_sequencer: hidden weights overlap the output weights");
  end

  function automatic logic [ADDR_W-1:0] addr_of(input logic ph, input logic [2:0] idx);
    logic [ADDR_W-1:0] ix;
    ix = ADDR_W'(idx);
    if (ph) return ADDR_W'(OUT_BASE) + ix * ADDR_W'(N_HID);
    return ADDR_W'(HID_BASE) + ix * ADDR_W'(N_IN);
  endfunction

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              cap_hid_q, cap_hid_d;
  logic              cap_out_q, cap_out_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              running;

  assign running = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPT);

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      idx_q     <= 3'd0;
      addr_q    <= '0;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      cap_hid_q <= 1'b0;
      cap_out_q <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      cap_hid_q <= cap_hid_d;
      cap_out_q <= cap_out_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  // A weight load wins over every in-frame transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (seq_if.Start && !seq_if.WE) state_d = S_ISSUE;
      S_ISSUE: begin
        if (seq_if.WE)        state_d = S_IDLE;
        else if (RD_LAT == 0) state_d = S_CAPT;
        else                  state_d = S_WAIT;
      end
      S_WAIT: begin
        if (seq_if.WE)          state_d = S_IDLE;
        else if (cnt_q == 3'd0) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (seq_if.WE)                         state_d = S_IDLE;
        else if (phase_q && idx_q == LAST_OUT) state_d = S_DONE;
        else                                   state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every strobe comes straight off a flop.
  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    busy_d    = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CAPT);
    cap_hid_d = (state_d == S_CAPT) && !phase_q;
    cap_out_d = (state_d == S_CAPT) && phase_q;
    done_d    = (state_d == S_DONE);
    abort_d   = running && seq_if.WE;

    if (state_q == S_IDLE && state_d == S_ISSUE) begin
      phase_d = 1'b0;
      idx_d   = 3'd0;
      addr_d  = addr_of(1'b0, 3'd0);
    end else if (state_q == S_CAPT && state_d == S_ISSUE) begin
      if (!phase_q && idx_q == LAST_HID) begin
        phase_d = 1'b1;
        idx_d   = 3'd0;
      end else begin
        idx_d   = idx_q + 3'd1;
      end
      addr_d = addr_of(phase_d, idx_d);
    end

    if (state_q == S_ISSUE && state_d == S_WAIT)     cnt_d = LAT_LOAD;
    else if (state_q == S_WAIT && state_d == S_WAIT) cnt_d = cnt_q - 3'd1;
  end

  assign seq_if.Address    = addr_q;
  assign seq_if.Phase      = phase_q;
  assign seq_if.NeuronIdx  = idx_q;
  assign seq_if.CaptureHid = cap_hid_q;
  assign seq_if.CaptureOut = cap_out_q;
  assign seq_if.Busy       = busy_q;
  assign seq_if.Done       = done_q;
  assign seq_if.Abort      = abort_q;
  assign seq_if.State      = state_q;

`ifdef NN_SEQ_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge Clock) begin
    if (Rst)         fcnt_q <= 8'd0;
    else if (done_d) fcnt_q <= fcnt_q + 8'd1;
  end

  assign seq_if.FrameCnt = fcnt_q;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: RD_LAT=1 main instance plus RD_LAT=0/3 timing instances.
module tb_nn_layer_sequencer;

  logic Clock = 1'b0;
  logic Rst   = 1'b1;
  logic start = 1'b0;
  logic we    = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 Clock = ~Clock;

  nn_layer_sequencer_if #(.ADDR_W(7)) b1 ();
  nn_layer_sequencer_if #(.ADDR_W(7)) b0 ();
  nn_layer_sequencer_if #(.ADDR_W(7)) b3 ();

  assign b1.Start = start;
  assign b0.Start = start;
  assign b3.Start = start;
  assign b1.WE    = we;
  assign b0.WE    = we;
  assign b3.WE    = we;

  nn_layer_sequencer #(.RD_LAT(1)) u_dut1 (.Clock(Clock), .Rst(Rst), .seq_if(b1));
  nn_layer_sequencer #(.RD_LAT(0)) u_dut0 (.Clock(Clock), .Rst(Rst), .seq_if(b0));
  nn_layer_sequencer #(.RD_LAT(3)) u_dut3 (.Clock(Clock), .Rst(Rst), .seq_if(b3));

  typedef struct {
    logic [6:0] addr;
    logic       ph;
    logic [2:0] idx;
    int         cyc1;
    int         cyc0;
    int         cyc3;
  } cap_vec_t;

  cap_vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // One frame on all three instances; cycle 0 is the first ISSUE cycle.
  task automatic run_frame();
    int k1 = 0, k0 = 0, k3 = 0;
    int d1 = -1, d0 = -1, d3 = -1;
    bit multi = 0;
    @(negedge Clock); start = 1'b1;
    @(negedge Clock); start = 1'b0;
    chk("issue_state", b1.State, 1);
    chk("issue_busy", b1.Busy, 1);
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) @(negedge Clock);
      if (b1.CaptureHid || b1.CaptureOut) begin
        if (k1 < 8) begin
          chk("cap1_cycle", c, vt[k1].cyc1);
          chk("cap1_addr", b1.Address, vt[k1].addr);
          chk("cap1_phase", b1.Phase, vt[k1].ph);
          chk("cap1_idx", b1.NeuronIdx, vt[k1].idx);
          chk("cap1_kind", b1.CaptureOut, vt[k1].ph);
        end
        k1++;
      end
      if (b0.CaptureHid || b0.CaptureOut) begin
        if (k0 < 8) begin
          chk("cap0_cycle", c, vt[k0].cyc0);
          chk("cap0_addr", b0.Address, vt[k0].addr);
        end
        k0++;
      end
      if (b3.CaptureHid || b3.CaptureOut) begin
        if (k3 < 8) begin
          chk("cap3_cycle", c, vt[k3].cyc3);
          chk("cap3_addr", b3.Address, vt[k3].addr);
        end
        k3++;
      end
      if (b1.Done) begin
        if (d1 < 0) d1 = c;
        chk("done_busy", b1.Busy, 0);
      end
      if (b0.Done && d0 < 0) d0 = c;
      if (b3.Done && d3 < 0) d3 = c;
      if ($countones({b1.CaptureHid, b1.CaptureOut, b1.Done, b1.Abort}) > 1) multi = 1;
    end
    chk("done1_cycle", d1, 24);
    chk("done0_cycle", d0, 16);
    chk("done3_cycle", d3, 40);
    chk("caps1_count", k1, 8);
    chk("caps0_count", k0, 8);
    chk("caps3_count", k3, 8);
    chk("strobe_exclusive", multi, 0);
  endtask

  initial begin
    int n;
    bit stay_idle;
    vt[0] = '{7'd0,  1'b0, 3'd0,  2,  1,  4};
    vt[1] = '{7'd10, 1'b0, 3'd1,  5,  3,  9};
    vt[2] = '{7'd20, 1'b0, 3'd2,  8,  5, 14};
    vt[3] = '{7'd30, 1'b0, 3'd3, 11,  7, 19};
    vt[4] = '{7'd40, 1'b0, 3'd4, 14,  9, 24};
    vt[5] = '{7'd50, 1'b1, 3'd0, 17, 11, 29};
    vt[6] = '{7'd55, 1'b1, 3'd1, 20, 13, 34};
    vt[7] = '{7'd60, 1'b1, 3'd2, 23, 15, 39};

    // Reset state
    @(negedge Clock);
    chk("rst_state", b1.State, 0);
    chk("rst_addr", b1.Address, 0);
    chk("rst_phase_idx", {b1.Phase, b1.NeuronIdx}, 0);
    chk("rst_strobes", {b1.CaptureHid, b1.CaptureOut, b1.Done, b1.Abort, b1.Busy}, 0);
    @(negedge Clock); Rst = 1'b0;
    @(negedge Clock);
    chk("idle_state", b1.State, 0);

    run_frame();

    // Start held high: Done, one IDLE cycle, then a new ISSUE
    @(negedge Clock); start = 1'b1;
    n = 0;
    while (!b1.Done && n < 40) begin @(negedge Clock); n++; end
    chk("cont_done_seen", b1.Done, 1);
    @(negedge Clock);
    chk("cont_gap_idle", b1.State, 0);
    @(negedge Clock);
    chk("cont_reissue", b1.State, 1);
    chk("cont_reissue_addr", b1.Address, 0);
    start = 1'b0;
    repeat (5) @(negedge Clock);
    start = 1'b1;
    @(negedge Clock); start = 1'b0;
    n = 0;
    while (!b1.Done && n < 40) begin @(negedge Clock); n++; end
    chk("pulse_done_seen", b1.Done, 1);
    stay_idle = 1;
    repeat (4) begin
      @(negedge Clock);
      if (b1.State != 3'd0 || b1.Busy) stay_idle = 0;
    end
    chk("no_queued_frame", stay_idle, 1);

    // Abort in the CAPT cycle of hidden neuron 2
    @(negedge Clock); start = 1'b1;
    @(negedge Clock); start = 1'b0;
    n = 0;
    while (!(b1.State == 3'd3 && !b1.Phase && b1.NeuronIdx == 3'd2) && n < 40) begin
      @(negedge Clock); n++;
    end
    chk("abort_target_seen", b1.State, 3);
    we = 1'b1;
    @(negedge Clock); we = 1'b0;
    chk("abort_pulse", b1.Abort, 1);
    chk("abort_no_cap", {b1.CaptureHid, b1.CaptureOut}, 0);
    chk("abort_busy", b1.Busy, 0);
    chk("abort_state", b1.State, 0);
    chk("abort_no_done", b1.Done, 0);
    @(negedge Clock);
    chk("abort_one_cycle", b1.Abort, 0);
    start = 1'b1;
    @(negedge Clock); start = 1'b0;
    chk("restart_state", b1.State, 1);
    chk("restart_addr", b1.Address, 0);
    chk("restart_idx", {b1.Phase, b1.NeuronIdx}, 0);

    // Reset in WAIT of output neuron 1
    n = 0;
    while (!(b1.State == 3'd2 && b1.Phase && b1.NeuronIdx == 3'd1) && n < 40) begin
      @(negedge Clock); n++;
    end
    chk("rst_target_seen", b1.State, 2);
    Rst = 1'b1;
    @(negedge Clock); Rst = 1'b0;
    chk("midrst_state", b1.State, 0);
    chk("midrst_addr", b1.Address, 0);
    chk("midrst_phase_idx", {b1.Phase, b1.NeuronIdx}, 0);
    chk("midrst_outs", {b1.CaptureHid, b1.CaptureOut, b1.Done, b1.Abort, b1.Busy}, 0);
    @(negedge Clock);
    chk("midrst_after", {b1.CaptureHid, b1.CaptureOut, b1.Done, b1.Abort, b1.State}, 0);

`ifdef NN_SEQ_FRAME_CNT_EN
    Rst = 1'b1;
    @(negedge Clock); Rst = 1'b0;
    chk("fcnt_reset", b1.FrameCnt, 0);
    start = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 257 * 26 + 100 && n < 257; cyc++) begin
      @(negedge Clock);
      if (b1.Done) n++;
    end
    start = 1'b0;
    chk("fcnt_frames", n, 257);
    repeat (3) @(negedge Clock);
    chk("fcnt_wrap", b1.FrameCnt, 1);
    start = 1'b1;
    @(negedge Clock); start = 1'b0;
    repeat (4) @(negedge Clock);
    we = 1'b1;
    @(negedge Clock); we = 1'b0;
    chk("fcnt_abort_pulse", b1.Abort, 1);
    repeat (2) @(negedge Clock);
    chk("fcnt_abort_hold", b1.FrameCnt, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
